// File: rtl/weight_bram_sequencer.sv
// -----------------------------------------------------------------------------
// weight_bram_sequencer
//
// Purpose:
//   Controller for a single ANN weight BRAM (DEPTH words of DATA_W bits,
//   ADDR_W-bit address, negedge-clocked, write-first when WE=1). It is the
//   only driver of the BRAM port and runs one of two operations per START:
//     LOAD (MODE=1): accept DEPTH words from a loader over LD_VALID/LD_READY
//                    and write them to addresses 0..DEPTH-1.
//     READ (MODE=0): read addresses 0..DEPTH-1 in order and stream the words
//                    to the neuron MAC over W_VALID/W_READY.
//
// Ports:
//   CLK, RSTN           system clock (posedge), async active-low reset
//   START, MODE         begin an operation (sampled only in IDLE), 0=READ 1=LOAD
//   LD_DATA/VALID/READY loader handshake (LOAD mode)
//   W_DATA/VALID/READY  weight stream to the MAC (READ mode)
//   W_LAST, W_IDX       last-word flag and index of the word on W_DATA
//   BUSY, DONE          not-idle status, one-cycle end-of-operation pulse
//   BRAM_ADDR/DI/EN/WE  registered BRAM port controls
//   BRAM_DO             BRAM read data, valid the posedge after an EN=1,WE=0 cycle
//   CHECKSUM            (only with WEIGHT_SEQ_CHECKSUM_EN) modulo-2^DATA_W sum of
//                       all words handshaken since the last accepted START
//
// Build option:
//   `define WEIGHT_SEQ_CHECKSUM_EN to add the CHECKSUM output and its logic.
// -----------------------------------------------------------------------------
module weight_bram_sequencer #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  input  logic              MODE,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_VALID,
  output logic              LD_READY,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  output logic [ADDR_W-1:0] W_IDX,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [DATA_W-1:0] BRAM_DI,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  input  logic [DATA_W-1:0] BRAM_DO
`ifdef WEIGHT_SEQ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] CHECKSUM
`endif
);

  // Index of the final word; all address generation stops here (no wrap).
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_LOAD_WR   = 3'd2,
    S_FETCH     = 3'd3,
    S_STREAM    = 3'd4,
    S_FIN       = 3'd5
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   idx_q,       idx_d;
  logic [DATA_W-1:0]   w_data_q,    w_data_d;
  logic                w_valid_q,   w_valid_d;
  logic                w_last_q,    w_last_d;
  logic [ADDR_W-1:0]   w_idx_q,     w_idx_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_di_q,   bram_di_d;
  logic                bram_en_q,   bram_en_d;
  logic                bram_we_q,   bram_we_d;

  // Handshake strobes, shared by the FSM and the optional checksum.
  logic start_accept;
  logic ld_fire;
  logic w_fire;

  assign start_accept = (state_q == S_IDLE) && START;
  assign ld_fire      = (state_q == S_LOAD_WAIT) && LD_VALID;
  assign w_fire       = (state_q == S_STREAM) && w_valid_q && W_READY;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      w_data_q    <= '0;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
      w_idx_q     <= '0;
      bram_addr_q <= '0;
      bram_di_q   <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      w_data_q    <= w_data_d;
      w_valid_q   <= w_valid_d;
      w_last_q    <= w_last_d;
      w_idx_q     <= w_idx_d;
      bram_addr_q <= bram_addr_d;
      bram_di_q   <= bram_di_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-register logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    w_data_d    = w_data_q;
    w_valid_d   = w_valid_q;
    w_last_d    = w_last_q;
    w_idx_d     = w_idx_q;
    bram_addr_d = bram_addr_q;
    bram_di_d   = bram_di_q;
    bram_en_d   = bram_en_q;
    bram_we_d   = bram_we_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_accept) begin
          idx_d = '0;
          if (MODE) begin
            state_d = S_LOAD_WAIT;
          end else begin
            // Launch the read of word 0 right away so its data is on
            // BRAM_DO at the next posedge.
            state_d     = S_FETCH;
            bram_addr_d = '0;
            bram_en_d   = 1'b1;
            bram_we_d   = 1'b0;
          end
        end
      end

      S_LOAD_WAIT: begin
        if (ld_fire) begin
          bram_di_d   = LD_DATA;
          bram_addr_d = idx_q;
          bram_en_d   = 1'b1;
          bram_we_d   = 1'b1;
          state_d     = S_LOAD_WR;
        end
      end

      S_LOAD_WR: begin
        // The BRAM commits the write on the negedge inside this cycle.
        bram_en_d = 1'b0;
        bram_we_d = 1'b0;
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_LOAD_WAIT;
        end
      end

      S_FETCH: begin
        w_data_d  = BRAM_DO;
        w_valid_d = 1'b1;
        w_idx_d   = idx_q;
        w_last_d  = (idx_q == LAST_IDX);
        bram_en_d = 1'b0;
        state_d   = S_STREAM;
      end

      S_STREAM: begin
        // W_DATA/W_IDX/W_LAST hold by default until the consumer takes the word.
        if (w_fire) begin
          w_valid_d = 1'b0;
          w_last_d  = 1'b0;
          if (w_last_q) begin
            state_d = S_FIN;
          end else begin
            idx_d       = idx_q + ADDR_W'(1);
            bram_addr_d = idx_q + ADDR_W'(1);
            bram_en_d   = 1'b1;
            bram_we_d   = 1'b0;
            state_d     = S_FETCH;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Status flags decode the state register directly so they are
  // glitch-free and drop to 0 together with the async reset.
  // ---------------------------------------------------------------------------
  assign LD_READY  = (state_q == S_LOAD_WAIT);
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = (state_q == S_FIN);
  assign W_DATA    = w_data_q;
  assign W_VALID   = w_valid_q;
  assign W_LAST    = w_last_q;
  assign W_IDX     = w_idx_q;
  assign BRAM_ADDR = bram_addr_q;
  assign BRAM_DI   = bram_di_q;
  assign BRAM_EN   = bram_en_q;
  assign BRAM_WE   = bram_we_q;

`ifdef WEIGHT_SEQ_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running checksum of every word crossing either handshake. Cleared when a
  // START is accepted and held through FIN/IDLE until the next one.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) begin
      checksum_d = '0;
    end else if (ld_fire) begin
      checksum_d = checksum_q + LD_DATA;
    end else if (w_fire) begin
      checksum_d = checksum_q + w_data_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign CHECKSUM = checksum_q;
`else
  // Checksum feature not built: no extra state or port.
`endif

endmodule

// File: doc/weight_bram_sequencer.md
Name: weight_bram_sequencer

Overview:
- Controller for one ANN weight BRAM: 28 x 16-bit words, 5-bit address, negedge-clocked, write-first when WE=1, read otherwise.
- Two modes, selected at START:
  - LOAD: accepts words from a loader over a valid/ready handshake and writes BRAM addresses 0..DEPTH-1.
  - READ: reads addresses 0..DEPTH-1 in order and streams the words to the neuron MAC over a valid/ready handshake.
- Sits between the BRAM and the layer datapath. It is the only driver of the BRAM port.

Parameters:
- DEPTH, 28, number of weight words sequenced per operation (1..32).
- ADDR_W, 5, BRAM address width.
- DATA_W, 16, weight word width.

Ports:
- CLK  in  1  system clock; FSM and all registers on posedge.
- RSTN  in  1  asynchronous active-low reset.
- START  in  1  begin an operation; sampled only in IDLE.
- MODE  in  1  0=READ, 1=LOAD; sampled with START.
- LD_DATA  in  DATA_W  word to write.
- LD_VALID  in  1  LD_DATA valid.
- LD_READY  out  1  sequencer accepts LD_DATA.
- W_DATA  out  DATA_W  streamed weight (registered).
- W_VALID  out  1  W_DATA valid.
- W_READY  in  1  consumer accepts W_DATA.
- W_LAST  out  1  high with W_VALID on word DEPTH-1.
- W_IDX  out  ADDR_W  index of current word.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle pulse at end of operation.
- BRAM_ADDR  out  ADDR_W  registered.
- BRAM_DI  out  DATA_W  registered.
- BRAM_EN  out  1  registered.
- BRAM_WE  out  1  registered.
- BRAM_DO  in  DATA_W  BRAM read data; valid at the posedge after an EN=1, WE=0 cycle.

Behaviour:
- Reset (async, RSTN=0):
  - State=IDLE, idx=0.
  - All outputs 0: LD_READY, W_VALID, W_LAST, W_DATA, W_IDX, BUSY, DONE, BRAM_*.
  - Reset mid-operation abandons it; no DONE is issued. BRAM contents are untouched, except that a write already launched may complete.
- States: IDLE, LOAD_WAIT, LOAD_WR, FETCH, STREAM, FIN.
- IDLE:
  - START=1, MODE=1 -> LOAD_WAIT, idx=0.
  - START=1, MODE=0 -> FETCH, with BRAM_ADDR<=0, BRAM_EN<=1, BRAM_WE<=0.
  - START is ignored in every other state.
- LOAD_WAIT:
  - LD_READY=1.
  - On LD_VALID & LD_READY: BRAM_DI<=LD_DATA, BRAM_ADDR<=idx, BRAM_EN<=1, BRAM_WE<=1 -> LOAD_WR.
- LOAD_WR:
  - LD_READY=0; the write occurs at the negedge of this cycle.
  - Next posedge: BRAM_EN<=0, BRAM_WE<=0.
  - If idx==DEPTH-1 -> FIN; else idx++ -> LOAD_WAIT.
  - Maximum rate: 1 word per 2 cycles.
- FETCH:
  - BRAM_EN=1 this cycle.
  - Next posedge: W_DATA<=BRAM_DO, W_VALID<=1, W_IDX<=idx, W_LAST<=(idx==DEPTH-1), BRAM_EN<=0 -> STREAM.
- STREAM:
  - W_DATA, W_IDX, W_LAST are held stable while W_VALID=1 and W_READY=0.
  - On W_VALID & W_READY: W_VALID<=0, W_LAST<=0.
    - If last -> FIN.
    - Else idx++, BRAM_ADDR<=idx+1, BRAM_EN<=1 -> FETCH.
  - Maximum rate: 1 word per 2 cycles.
- FIN: DONE=1 for exactly one cycle, then -> IDLE. BUSY drops in the same cycle IDLE is entered.
- Latency: START sampled at posedge P0 -> FETCH at P0 -> W_VALID high after P1 (word 0).
- Other rules:
  - Address never exceeds DEPTH-1; there is no wrap-around.
  - idx width is ADDR_W; no arithmetic beyond the increment.
  - LD_VALID outside LOAD_WAIT is ignored (LD_READY=0).
  - W_READY while W_VALID=0 has no effect.

Optional Feature:
- Macro WEIGHT_SEQ_CHECKSUM_EN.
- Defined:
  - Adds output CHECKSUM [DATA_W-1:0]: a modulo-2^DATA_W sum of every word accepted (LOAD handshakes) or delivered (READ handshakes).
  - Cleared to 0 on reset and when START is accepted.
  - Updated the posedge after each handshake.
  - Holds its value after FIN until the next START.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- LOAD, no backpressure: START, MODE=1, LD_VALID held 1, LD_DATA=16'h0100+i -> 28 writes, addresses 0..27, one per 2 cycles; DONE pulses once; BUSY low the cycle after DONE.
- READ after that load, W_READY=1 -> W_DATA 16'h0100..16'h011B in order; W_IDX 0..27; W_LAST only with 16'h011B; first W_VALID 2 posedges after START.
- READ with W_READY low 5 cycles on word 3 -> W_DATA=16'h0103 and W_IDX=3 stable; BRAM_EN=0 throughout the stall; stream resumes at word 4.
- Reset mid-READ (RSTN=0 at word 10) -> all outputs 0 immediately, no DONE; a new READ restarts from word 0.
- START pulses during LOAD and MODE toggles mid-op -> ignored; an LD_VALID gap of 7 cycles stalls the FSM in LOAD_WAIT without writes.
- With WEIGHT_SEQ_CHECKSUM_EN, READ of the 16'h0100+i pattern -> CHECKSUM=16'h1D7A after DONE; it clears to 0 on the next START.
